otter_alu_arbiter: RTL
======================

# otter_alu_arbiter

Shares one OTTER ALU between two requesters, e.g. the pipeline execute stage (port 0) and a coprocessor/debug unit (port 1). Round-robin arbitration over valid/ready request channels, one registered result stage, and response steering back to the granted requester with backpressure. Sits between the requesters and a single internal ALU instance, so the design keeps one multiplier.

## Interface
- WIDTH, 32, operand/result width
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- req_valid  in  2  request present, one bit per requester
- req_ready  out  2  request accepted this cycle when valid&ready
- req_fun  in  2x4  ALU function code {func7[5],func3} per requester
- req_a  in  2xWIDTH  operand A per requester
- req_b  in  2xWIDTH  operand B per requester
- rsp_valid  out  2  result available for that requester
- rsp_ready  in  2  requester consumes result
- rsp_data  out  2xWIDTH  result; zero when that rsp_valid is low
- rsp_err  out  2  function code was unsupported; rsp_data is 0

## Operation
- Function codes: 0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 or, 7 and, 8 sub, 9 copy A (lui), 10 mul (low WIDTH bits), 13 sra. Codes 11, 12, 14, 15 are unsupported: the result is 0 and err is 1.
- State: output register (out_valid, out_owner, out_data, out_err) and priority pointer prio (0 or 1).
- can_accept = !out_valid || rsp_ready[out_owner].
- Grant is combinational:
  - If only one req_valid is set, that requester is granted.
  - If both are set, requester prio is granted.
- req_ready[g] = can_accept for the granted g. The ungranted port gets req_ready 0.
- req_ready does not depend on that port's own req_valid being stable. The requester holds fun/a/b stable while valid && !ready.
- On accept: out_data <= ALU(fun,a,b), out_err <= unsupported(fun), out_owner <= g, out_valid <= 1, prio <= ~g (the last winner drops to low priority).
- On drain without accept (rsp_ready[out_owner] && out_valid && no accept): out_valid <= 0.
- rsp_valid[i] = out_valid && out_owner==i. rsp_data[i] and rsp_err[i] are gated to 0 otherwise.
- rsp_ready of the non-owner is ignored.

## Timing
- Reset values: out_valid 0, out_owner 0, out_data 0, out_err 0, prio 0, all rsp_valid/rsp_data/rsp_err 0.
- req_ready is 1 for requester 0 when it is valid after reset, or for requester 1 if only it is valid.
- Latency: a request accepted at edge N gives rsp_valid at N+1.
- Throughput: one op per cycle while owners keep rsp_ready high. Drain and a new accept can occur on the same edge, so there are no bubbles.
- Backpressure: while out_valid && !rsp_ready[out_owner], req_ready is 0 on both ports and out_* hold stable.
- Both requesters continuously valid: grants alternate 0,1,0,1. Neither port waits more than one accept.
- Reset asserted mid-operation clears the pending result immediately (asynchronous); the result is lost, not replayed.
- No combinational path from rsp_ready to rsp_valid. The path rsp_ready -> req_ready is combinational and allowed.

## Structure
- Package otter_alu_pkg:
  - enum alu_fun_t with the codes above
  - function alu_fun_supported(alu_fun_t)
  - constants NUM_REQ=2 and ALU_FUN_W=4
- One sub-module: the existing OTTER_ALU, instantiated once, fed by a 2:1 operand mux on the grant.
- Arbiter logic and the output register live in otter_alu_arbiter.

## Test plan
- Reset, then req0 add A=5 B=7 with rsp_ready0=1 -> req_ready0 in the same cycle; next cycle rsp_valid0=1, rsp_data0=12, rsp_valid1=0.
- Both valid every cycle: req0 sub 10-3, req1 mul 6*7, rsp_ready high -> grants 0,1,0,1; responses 7 on port0 and 42 on port1 on alternating cycles.
- rsp_ready0=0 for 3 cycles after req0 sra A=0x80000000 B=4 -> rsp_data0 holds 0xF8000000, req_ready both 0; on release, the next queued req1 is accepted on the same edge.
- req1 fun=11 A=1 B=1 -> rsp_valid1=1, rsp_err1=1, rsp_data1=0.
- Assert RST_N low while out_valid=1 -> all rsp outputs go 0 immediately and prio=0; after release, simultaneous requests grant port 0 first.
- Back-to-back req0 slt (-1,1) then sltu (0xFFFFFFFF,1) with rsp_ready0=1 -> results 1 then 0 on consecutive cycles, no bubble.

Source files
------------

// File: rtl/otter_alu_pkg.sv
// rtl/otter_alu_pkg.sv - shared types and constants for the OTTER ALU arbiter
//
// Contents:
//   NUM_REQ            number of requesters sharing the ALU
//   ALU_FUN_W          width of the {func7[5],func3} function code
//   alu_fun_t          ALU function encodings
//   alu_fun_supported  1 when the code selects a real operation
package otter_alu_pkg;

  localparam int NUM_REQ   = 2;
  localparam int ALU_FUN_W = 4;

  typedef enum logic [ALU_FUN_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_LUI  = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_SRA  = 4'd13
  } alu_fun_t;

  function automatic logic alu_fun_supported(alu_fun_t fun);
    case (fun)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
      ALU_OR, ALU_AND, ALU_SUB, ALU_LUI, ALU_MUL, ALU_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_alu.sv
// rtl/otter_alu.sv - combinational OTTER ALU, single shared instance
//
// Ports:
//   fun_i     function code (alu_fun_t)
//   a_i, b_i  operands
//   result_o  operation result, 0 for unsupported codes
//   err_o     1 when fun_i is not a supported code
module otter_alu
  import otter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_fun_t         fun_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] product;

  assign shamt   = b_i[SHW-1:0];
  // Only the low WIDTH bits of the product are kept.
  assign product = a_i * b_i;

  always_comb begin
    result_o = '0;
    case (fun_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_LUI:  result_o = a_i;
      ALU_MUL:  result_o = product;
      default:  result_o = '0;
    endcase
    err_o = !alu_fun_supported(fun_i);
  end

endmodule

// File: rtl/otter_alu_arbiter.sv
// rtl/otter_alu_arbiter.sv - round-robin sharing of one OTTER ALU by two requesters
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   per-requester request handshake
//   req_fun_i, req_a_i, req_b_i   per-requester function code and operands
//   rsp_valid_o/rsp_ready_i   per-requester response handshake
//   rsp_data_o, rsp_err_o     per-requester result and unsupported-code flag,
//                             both 0 while that rsp_valid_o is low
module otter_alu_arbiter
  import otter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0][ALU_FUN_W-1:0] req_fun_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_a_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_b_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [NUM_REQ-1:0][WIDTH-1:0]    rsp_data_o,
  output logic [NUM_REQ-1:0]               rsp_err_o
);

  logic             out_valid_q, out_valid_d;
  logic             out_owner_q, out_owner_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_err_q,   out_err_d;
  logic             prio_q,      prio_d;

  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;

  // Contention goes to the pointer; otherwise the lone requester wins.
  // With nobody valid the grant idles on port 0, which is harmless since
  // accept also requires a valid request.
  always_comb begin
    if (req_valid_i[0] && req_valid_i[1]) grant = prio_q;
    else if (req_valid_i[1])              grant = 1'b1;
    else                                  grant = 1'b0;
  end

  // The result slot frees up on the same edge its owner consumes it.
  assign can_accept = !out_valid_q || rsp_ready_i[out_owner_q];
  assign accept     = (|req_valid_i) && can_accept;

  always_comb begin
    req_ready_o        = '0;
    req_ready_o[grant] = can_accept;
  end

  otter_alu #(.WIDTH(WIDTH)) u_alu (
    .fun_i    (alu_fun_t'(req_fun_i[grant])),
    .a_i      (req_a_i[grant]),
    .b_i      (req_b_i[grant]),
    .result_o (alu_result),
    .err_o    (alu_err)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_owner_d = out_owner_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    prio_d      = prio_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_owner_d = grant;
      out_data_d  = alu_result;
      out_err_d   = alu_err;
      prio_d      = ~grant;
    end else if (out_valid_q && rsp_ready_i[out_owner_q]) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_owner_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_owner_q <= out_owner_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      prio_q      <= prio_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = out_valid_q && (out_owner_q == 1'(i));
      rsp_data_o[i]  = rsp_valid_o[i] ? out_data_q : '0;
      rsp_err_o[i]   = rsp_valid_o[i] && out_err_q;
    end
  end

endmodule
